// File: rtl/instruction_fetch_unit_pkg.sv
// Shared processor definitions: FSM encodings, next-PC source codes, increment constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_fetch_unit_pkg;

    typedef logic [31:0] word_t;

    // Fetch FSM state encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    // Next-PC source select codes
    localparam logic [1:0] PC_SEL_ADDER = 2'b00;
    localparam logic [1:0] PC_SEL_RA    = 2'b01;
    localparam logic [1:0] PC_SEL_RESET = 2'b10;
    localparam logic [1:0] PC_SEL_HOLD  = 2'b11;

    // Sequential instruction stride in bytes
    localparam word_t PC_INC = 32'd4;

    // Force a byte address onto a word boundary
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port: strobe/address out, data/ready back.
// Latency: combinational wires only.
// Backpressure: memory stalls the fetcher by holding mem_ready low.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic  mem_read;
    word_t mem_addr;
    word_t mem_rdata;
    logic  mem_ready;

    modport master (
        output mem_read,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/instruction_fetch_unit_pc_next_logic.sv
// Next-PC computation: adder (+4 or +imm), source mux, word alignment, return address.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to load the result.
module pc_next_logic
    import instruction_fetch_unit_pkg::*;
#(
    parameter word_t RESET_VECTOR = 32'h0000_0000
) (
    input  word_t      pc_i,
    input  word_t      ra_i,
    input  word_t      imm_i,
    input  logic [1:0] pc_sel_i,
    input  logic       inc_sel_i,
    output word_t      pc_next_o,
    output word_t      pc_plus4_o,
    output logic       pc_load_o
);

    word_t adder_sum;

    // Adder wraps modulo 2^32; no carry is reported
    assign adder_sum  = pc_i + (inc_sel_i ? imm_i : PC_INC);
    assign pc_plus4_o = pc_i + PC_INC;
    assign pc_load_o  = (pc_sel_i != PC_SEL_HOLD);

    // Select next PC; computed targets are word aligned, the reset vector is taken verbatim
    always_comb begin
        pc_next_o = pc_i;
        case (pc_sel_i)
            PC_SEL_ADDER: pc_next_o = align_word(adder_sum);
            PC_SEL_RA:    pc_next_o = align_word(ra_i);
            PC_SEL_RESET: pc_next_o = RESET_VECTOR;
            default:      pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, fetch FSM (IDLE/REQ/WAIT/DONE), IR with timeout-to-NOP.
// Latency: FetchDone in the third cycle counting the IR_Enable accept cycle; +1 per stalled WAIT cycle.
// Backpressure: mem_ready low stalls in WAIT up to TIMEOUT cycles; IR_Enable while busy is dropped.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter word_t RESET_VECTOR = 32'h0000_0000,
    parameter word_t NOP_WORD     = 32'h0000_0000,
    parameter int    TIMEOUT      = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            pc_enable_i,
    input  logic [1:0]                      pc_select_i,
    input  logic                            inc_select_i,
    input  logic                            ir_enable_i,
    input  word_t                           immediate_i,
    input  word_t                           ra_i,
    instruction_fetch_unit_if.master        mem_if,
    output word_t                           instruction_o,
    output word_t                           pc_o,
    output word_t                           pc_temp_o,
    output logic                            fetch_done_o,
    output logic                            fetch_error_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state_q,       state_d;
    word_t            mem_addr_q,    mem_addr_d;
    word_t            ir_q,          ir_d;
    logic [CNT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic             fetch_error_q, fetch_error_d;
    word_t            pc_q,          pc_d;
    word_t            pc_temp_q,     pc_temp_d;

    word_t pc_next;
    word_t pc_plus4;
    logic  pc_load;

    pc_next_logic #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_next (
        .pc_i       (pc_q),
        .ra_i       (ra_i),
        .imm_i      (immediate_i),
        .pc_sel_i   (pc_select_i),
        .inc_sel_i  (inc_select_i),
        .pc_next_o  (pc_next),
        .pc_plus4_o (pc_plus4),
        .pc_load_o  (pc_load)
    );

    // Fetch FSM next state; the address is latched only on accept so PC moves cannot disturb it
    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        ir_d          = ir_q;
        wait_cnt_d    = wait_cnt_q;
        fetch_error_d = fetch_error_q;
        case (state_q)
            ST_IDLE: begin
                if (ir_enable_i) begin
                    mem_addr_d    = align_word(pc_q);
                    fetch_error_d = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                wait_cnt_d = '0;
                if (mem_if.mem_ready) begin
                    ir_d    = mem_if.mem_rdata;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_if.mem_ready) begin
                    ir_d    = mem_if.mem_rdata;
                    state_d = ST_DONE;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon the fetch: hand the pipeline a harmless instruction and flag it
                    ir_d          = NOP_WORD;
                    fetch_error_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PC and return-address next state, independent of the fetch FSM
    always_comb begin
        pc_d      = pc_q;
        pc_temp_d = pc_temp_q;
        if (pc_enable_i && pc_load) begin
            pc_d      = pc_next;
            pc_temp_d = pc_plus4;
        end
    end

    // State registers with synchronous reset that discards any in-flight fetch
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            mem_addr_q    <= '0;
            ir_q          <= NOP_WORD;
            wait_cnt_q    <= '0;
            fetch_error_q <= 1'b0;
            pc_q          <= RESET_VECTOR;
            pc_temp_q     <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            ir_q          <= ir_d;
            wait_cnt_q    <= wait_cnt_d;
            fetch_error_q <= fetch_error_d;
            pc_q          <= pc_d;
            pc_temp_q     <= pc_temp_d;
        end
    end

    // Status outputs are forced low while reset is held, even before the reset edge lands
    assign mem_if.mem_read = !rst_i && ((state_q == ST_REQ) || (state_q == ST_WAIT));
    assign mem_if.mem_addr = mem_addr_q;
    assign fetch_done_o    = !rst_i && (state_q == ST_DONE);
    assign fetch_error_o   = !rst_i && fetch_error_q;
    assign instruction_o   = ir_q;
    assign pc_o            = pc_q;
    assign pc_temp_o       = pc_temp_q;

endmodule
